// File: rtl/imm_op_sequencer.sv
// Multi-cycle sequencer for immediate-operand instructions: register read,
// ALU execute against the sign-extended imm8, then a single write-back.
module imm_op_sequencer #(
  parameter logic [3:0] OPC_ADDI = 4'h8,
  parameter logic [3:0] OPC_SUBI = 4'h9,
  parameter logic [3:0] OPC_LUI  = 4'hA,
  parameter logic [3:0] OPC_LLI  = 4'hB,
  parameter logic [2:0] ALU_ADD  = 3'b000,
  parameter logic [2:0] ALU_SUB  = 3'b001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  rf_raddr,
  input  logic [15:0] rf_rdata,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  output logic [15:0] imm_ext,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_WB, S_ERR} state_e;

  state_e      state_q, state_d;
  logic [3:0]  opc_q, opc_d;
  logic [3:0]  rd_q, rd_d;
  logic [15:0] imm_ext_q, imm_ext_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        xfer;
  logic [15:0] instr_sext;

  assign xfer       = instr_valid && instr_ready;
  assign instr_sext = {{8{instr[7]}}, instr[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      opc_q     <= '0;
      rd_q      <= '0;
      imm_ext_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      rd_q      <= rd_d;
      imm_ext_q <= imm_ext_d;
      wb_data_q <= wb_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    rd_d      = rd_q;
    imm_ext_d = imm_ext_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          opc_d     = instr[15:12];
          rd_d      = instr[11:8];
          imm_ext_d = instr_sext;
          if (instr[15:12] == OPC_ADDI || instr[15:12] == OPC_SUBI ||
              instr[15:12] == OPC_LUI) begin
            state_d = S_RD;
          end else if (instr[15:12] == OPC_LLI) begin
            // LLI needs no register read, so its result is known right away
            wb_data_d = instr_sext;
            state_d   = S_WB;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_RD: state_d = S_EX;
      S_EX: begin
        wb_data_d = (opc_q == OPC_LUI) ? {imm_ext_q[7:0], rf_rdata[7:0]} : alu_result;
        state_d   = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == S_IDLE) && !rst;
    busy        = (state_q != S_IDLE);
    rf_raddr    = '0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    imm_ext     = imm_ext_q;
    case (state_q)
      S_RD: rf_raddr = rd_q;
      S_EX: begin
        alu_a  = rf_rdata;
        alu_b  = imm_ext_q;
        alu_op = (opc_q == OPC_SUBI) ? ALU_SUB : ALU_ADD;
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = rd_q;
        rf_wdata = wb_data_q;
        done     = 1'b1;
      end
      S_ERR:   illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/imm_op_sequencer.md
Name: imm_op_sequencer

Overview: Multi-cycle controller that sequences immediate-operand instructions through the 16-bit datapath: register-file read, ALU execute with sign-extended 8-bit immediate, and write-back. It accepts one instruction at a time over a valid/ready handshake. It rebuilds imm8 from its immHigh/immLow nibbles and drives the register-file and shared-ALU ports. It sits between the decode stage and the register file/ALU.

Parameters:
OPC_ADDI, 4'h8, opcode for rd <= rd + sext(imm8)
OPC_SUBI, 4'h9, opcode for rd <= rd - sext(imm8)
OPC_LUI, 4'hA, opcode for rd <= {imm8, rd[7:0]}
OPC_LLI, 4'hB, opcode for rd <= sext(imm8)
ALU_ADD, 3'b000, alu_op code driven for ADDI
ALU_SUB, 3'b001, alu_op code driven for SUBI

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept
instr  in  16  [15:12] opcode, [11:8] rd, [7:4] immHigh, [3:0] immLow
rf_raddr  out  4  register-file read address (1-cycle read latency)
rf_rdata  in  16  read data, valid the cycle after rf_raddr is presented
rf_we  out  1  register-file write enable
rf_waddr  out  4  write address
rf_wdata  out  16  write data
alu_a  out  16  ALU operand A
alu_b  out  16  ALU operand B
alu_op  out  3  ALU operation
alu_result  in  16  combinational ALU result
imm_ext  out  16  registered {{8{imm8[7]}}, imm8} of the captured instruction
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on write-back
illegal  out  1  one-cycle pulse for an unsupported opcode

Behaviour:
- Reset (async, any state): state=IDLE. Registers opc/rd/imm_ext/wb_data=0. All outputs 0 except instr_ready, which is 1 once rst deasserts. A pending write is aborted; rf_we is never asserted after rst rises.
- Transfer occurs when instr_valid && instr_ready (IDLE only). Capture opcode, rd, imm8={immHigh,immLow}, imm_ext=sext(imm8).
- States: IDLE, RD, EX, WB, ERR.
  - IDLE: on transfer, go to RD for ADDI/SUBI/LUI. Go to WB for LLI, with wb_data=sext(imm8). Go to ERR for any other opcode.
  - RD: rf_raddr=rd. Go to EX.
  - EX: alu_a=rf_rdata, alu_b=imm_ext, alu_op=ALU_ADD/ALU_SUB. Latch wb_data=alu_result for ADDI/SUBI, or {imm8, rf_rdata[7:0]} for LUI. Go to WB.
  - WB: rf_we=1, rf_waddr=rd, rf_wdata=wb_data, done=1. Go to IDLE.
  - ERR: illegal=1, no write. Go to IDLE.
- Outputs are Moore, decoded from the state and held registers. alu_a/alu_b/alu_op and rf_raddr are 0 outside EX/RD respectively.
- Latency, with the transfer at cycle T:
  - ADDI/SUBI/LUI: WB at T+3.
  - LLI: WB at T+1.
  - Illegal: ERR at T+1.
  - In every case instr_ready returns the cycle after WB/ERR.
- Throughput: at most one instruction in flight. instr_valid held high while busy causes no transfer. The next transfer occurs in the first IDLE cycle.
- Arithmetic is modulo 2^16. Overflow and carry are ignored and no flags are produced.
- rd=0 is an ordinary register; there is no hard-wired zero.
- Outside IDLE, the instr input is ignored; changes to it after the transfer have no effect.

Test Plan:
- ADDI rd=3, imm8=0xF6, r3=0x0014 -> rf_raddr=3 at T+1; at T+2 alu_b=0xFFF6 and alu_op=000; at T+3 rf_we=1, waddr=3, wdata=0x000A, done=1; instr_ready=1 at T+4.
- SUBI rd=1, imm8=0x05, r1=0x0000 -> wdata=0xFFFB at T+3. Also ADDI r1=0xFFFF, imm8=0x01 -> wdata=0x0000 (wrap-around).
- LUI rd=2, imm8=0x80, r2=0x1234 -> wdata=0x8034 at T+3, alu_op irrelevant. LLI rd=5, imm8=0x7F -> wdata=0x007F at T+1. LLI imm8=0x80 -> 0xFF80, imm_ext=0xFF80.
- Opcode 0x3 -> illegal=1 at T+1, rf_we stays 0 for the whole sequence, instr_ready=1 at T+2. A following valid ADDI is accepted normally.
- instr_valid held high with back-to-back ADDI, LLI, ADDI -> exactly three transfers. Each transfer occurs only in an IDLE cycle; done pulses at T+3, then T'+1, then T''+3.
- rst asserted during EX of ADDI -> outputs 0 immediately, no rf_we afterwards. After deassert, instr_ready=1 and a new LLI completes at T+1.
